// File: rtl/te_ingress_serializer.sv
// Ingress serializer between the commit ports and the trace encoder: turns a bundle of
// retired uops into a one-beat-per-cycle valid/ready stream, folding all-STD bundles.
package mure_pkg;
    typedef enum logic [2:0] {
        STD  = 3'd0,
        UJ   = 3'd1,
        EXC  = 3'd2,
        INT  = 3'd3,
        ERET = 3'd4
    } itype_e;

    typedef struct packed {
        itype_e      itype;
        logic [31:0] pc;
        logic [31:0] instr;
    } uop_entry_s;
endpackage

module te_ingress_serializer #(
    parameter int unsigned NrRetiredInstr = 4,
    parameter bit          CompressStd    = 1'b1,
    parameter int unsigned CntW           = $clog2(NrRetiredInstr + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NrRetiredInstr-1:0]                 valid_i,
    input  mure_pkg::uop_entry_s [NrRetiredInstr-1:0] uop_i,
    output logic                                      ready_o,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output mure_pkg::uop_entry_s                      uop_o,
    output logic [CntW-1:0]                           count_o,
    output logic                                      drop_o
);
    import mure_pkg::*;

    localparam int unsigned IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e                           state_q, state_d;
    logic [NrRetiredInstr-1:0]        pend_q, pend_d;
    uop_entry_s                       uop_q, uop_d;
    logic [CntW-1:0]                  count_q, count_d;
    logic                             drop_q, drop_d;
    uop_entry_s [NrRetiredInstr-1:0]  buf_q;

    logic [NrRetiredInstr-1:0] eff_mask;
    logic [CntW-1:0]           eff_cnt;
    logic [IdxW-1:0]           hi_idx, first_idx, next_idx;
    logic                      all_std, trap_seen, compress, capture, last_beat;

    function automatic logic is_trap(input itype_e t);
        return (t == EXC) || (t == INT) || (t == ERET);
    endfunction

    function automatic logic [IdxW-1:0] lowest_idx(input logic [NrRetiredInstr-1:0] m);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = NrRetiredInstr - 1; i >= 0; i--) begin
            if (m[i]) idx = i[IdxW-1:0];
        end
        return idx;
    endfunction

    // Effective mask keeps everything up to and including the oldest trap entry.
    always_comb begin
        eff_mask  = '0;
        eff_cnt   = '0;
        hi_idx    = '0;
        all_std   = 1'b1;
        trap_seen = 1'b0;
        for (int i = 0; i < NrRetiredInstr; i++) begin
            if (valid_i[i] && !trap_seen) begin
                eff_mask[i] = 1'b1;
                eff_cnt     = eff_cnt + CntW'(1);
                hi_idx      = i[IdxW-1:0];
                if (uop_i[i].itype != STD) all_std = 1'b0;
                if (is_trap(uop_i[i].itype)) trap_seen = 1'b1;
            end
        end
    end

    assign compress  = CompressStd && (eff_cnt > CntW'(1)) && all_std;
    assign first_idx = lowest_idx(eff_mask);
    assign next_idx  = lowest_idx(pend_q);
    assign last_beat = (pend_q == '0);
    assign valid_o   = (state_q == EMIT);
    assign ready_o   = !valid_o || (ready_i && last_beat);
    assign capture   = ready_o && (|valid_i);
    assign uop_o     = uop_q;
    assign count_o   = count_q;
    assign drop_o    = drop_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        uop_d   = uop_q;
        count_d = count_q;
        drop_d  = capture && (eff_mask != valid_i);
        if (capture) begin
            state_d = EMIT;
            if (compress) begin
                uop_d   = uop_i[hi_idx];
                count_d = eff_cnt;
                pend_d  = '0;
            end else begin
                uop_d             = uop_i[first_idx];
                count_d           = CntW'(1);
                pend_d            = eff_mask;
                pend_d[first_idx] = 1'b0;
            end
        end else if ((state_q == EMIT) && ready_i) begin
            if (!last_beat) begin
                uop_d            = buf_q[next_idx];
                count_d          = CntW'(1);
                pend_d[next_idx] = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            uop_q   <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            uop_q   <= uop_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Later beats of a serialised bundle are replayed from this copy.
    always_ff @(posedge clk_i) begin
        if (capture) buf_q <= uop_i;
    end

endmodule

// File: tb/tb_te_ingress_serializer.sv
// Scoreboard bench: two serializers (folding on / off) share one randomized stimulus stream.
module tb_te_ingress_serializer;
    import mure_pkg::*;

    typedef struct packed {
        uop_entry_s  u;
        logic [2:0]  cnt;
    } beat_t;

    logic             clk, rst_n, ready_i;
    logic [3:0]       valid_i;
    uop_entry_s [3:0] uop_i;
    logic             ro1, vo1, dr1, ro0, vo0, dr0;
    uop_entry_s       uo1, uo0;
    logic [2:0]       co1, co0;

    beat_t      sb1[$], sb0[$], mq[$];
    logic [1:0] drop_next;
    int         total, bad;

    te_ingress_serializer #(.NrRetiredInstr(4), .CompressStd(1'b1)) u_c1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .uop_i(uop_i), .ready_o(ro1),
        .valid_o(vo1), .ready_i(ready_i), .uop_o(uo1), .count_o(co1), .drop_o(dr1));

    te_ingress_serializer #(.NrRetiredInstr(4), .CompressStd(1'b0)) u_c0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .uop_i(uop_i), .ready_o(ro0),
        .valid_o(vo0), .ready_i(ready_i), .uop_o(uo0), .count_o(co0), .drop_o(dr0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: list valid ports in age order, stop after the first trap, then either
    // fold an all-STD multi-entry list into one counted beat or emit one beat per entry.
    function automatic bit model(input logic [3:0] v, input uop_entry_s [3:0] u, input bit comp);
        int idx[$];
        bit allstd, trap, dropped;
        allstd = 1'b1; trap = 1'b0; dropped = 1'b0;
        mq = {};
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                if (trap) dropped = 1'b1;
                else begin
                    idx.push_back(i);
                    if (u[i].itype != STD) allstd = 1'b0;
                    if (u[i].itype inside {EXC, INT, ERET}) trap = 1'b1;
                end
            end
        end
        if (comp && idx.size() > 1 && allstd)
            mq.push_back('{u: u[idx[idx.size()-1]], cnt: 3'(idx.size())});
        else
            foreach (idx[j]) mq.push_back('{u: u[idx[j]], cnt: 3'd1});
        return dropped;
    endfunction

    function automatic uop_entry_s mk(input itype_e t);
        uop_entry_s e;
        e.itype = t;
        e.pc    = $urandom;
        e.instr = $urandom;
        return e;
    endfunction

    function automatic itype_e rnd_type();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return STD;
        if (r == 6) return UJ;
        if (r == 7) return EXC;
        if (r == 8) return INT;
        return ERET;
    endfunction

    task automatic capture_step();
        bit d;
        drop_next = '0;
        if (rst_n && (|valid_i)) begin
            if (ro1) begin
                d = model(valid_i, uop_i, 1'b1);
                foreach (mq[j]) sb1.push_back(mq[j]);
                drop_next[1] = d;
            end
            if (ro0) begin
                d = model(valid_i, uop_i, 1'b0);
                foreach (mq[j]) sb0.push_back(mq[j]);
                drop_next[0] = d;
            end
        end
    endtask

    // One clock of stimulus: drive after the falling edge, record captures before the rising edge.
    task automatic drive(input logic [3:0] v, input uop_entry_s [3:0] u, input logic ri, input logic rn);
        @(negedge clk);
        #1;
        valid_i = v;
        uop_i   = u;
        ready_i = ri;
        rst_n   = rn;
        if (!rn) begin
            sb1.delete();
            sb0.delete();
            drop_next = '0;
        end
        #3;
        capture_step();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb1.size() > 0 || sb0.size() > 0) && k < 40) begin
            drive(4'b0000, uop_i, 1'b1, 1'b1);
            k++;
        end
        cmp("drain", 128'(sb1.size() + sb0.size()), 128'(0));
    endtask

    task automatic chk(input string nm, input int n, input beat_t hd, input logic rn,
                       input logic vo, input logic ro, input logic ri, input logic dro,
                       input logic ed, input uop_entry_s uo, input logic [2:0] co,
                       output bit pop);
        pop = 1'b0;
        cmp({nm, ".valid_o"}, 128'(vo), 128'(n > 0));
        cmp({nm, ".ready_o"}, 128'(ro), 128'((n == 0) || (ri && n == 1)));
        cmp({nm, ".drop_o"}, 128'(dro), 128'(ed));
        if (!rn) begin
            cmp({nm, ".rst_uop"}, 128'(uo), 128'(0));
            cmp({nm, ".rst_count"}, 128'(co), 128'(0));
        end else if (vo && n > 0) begin
            cmp({nm, ".uop_o"}, 128'(uo), 128'(hd.u));
            cmp({nm, ".count_o"}, 128'(co), 128'(hd.cnt));
            pop = ri;
        end
    endtask

    initial begin : monitor
        bit    pop;
        beat_t hd;
        forever begin
            @(negedge clk);
            #3;
            hd = (sb1.size() > 0) ? sb1[0] : beat_t'(0);
            chk("c1", sb1.size(), hd, rst_n, vo1, ro1, ready_i, dr1, drop_next[1], uo1, co1, pop);
            if (pop) void'(sb1.pop_front());
            hd = (sb0.size() > 0) ? sb0[0] : beat_t'(0);
            chk("c0", sb0.size(), hd, rst_n, vo0, ro0, ready_i, dr0, drop_next[0], uo0, co0, pop);
            if (pop) void'(sb0.pop_front());
        end
    end

    initial begin : stimulus
        uop_entry_s [3:0] u;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        valid_i = '0;
        uop_i = '0;
        ready_i = 1'b0;
        drop_next = '0;
        drive(4'b0000, '0, 1'b0, 1'b0);
        drive(4'b0000, '0, 1'b1, 1'b0);
        drive(4'b0000, '0, 1'b1, 1'b1);

        // all-STD full bundle
        for (int i = 0; i < 4; i++) u[i] = mk(STD);
        drive(4'b1111, u, 1'b1, 1'b1);
        wait_idle();

        // UJ in the middle blocks folding
        u[0] = mk(STD); u[1] = mk(UJ); u[2] = mk(STD); u[3] = mk(STD);
        drive(4'b0111, u, 1'b1, 1'b1);
        wait_idle();

        // trap at port 1 discards ports 2 and 3
        u[0] = mk(STD); u[1] = mk(EXC); u[2] = mk(STD); u[3] = mk(STD);
        drive(4'b1111, u, 1'b1, 1'b1);
        wait_idle();

        // sparse bundle under backpressure
        for (int i = 0; i < 4; i++) u[i] = mk(STD);
        drive(4'b1010, u, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b0000, u, 1'b0, 1'b1);
        wait_idle();

        // back-to-back bundles
        u[0] = mk(STD);
        drive(4'b0001, u, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) u[i] = mk(rnd_type());
        drive(4'b0110, u, 1'b1, 1'b1);
        wait_idle();

        // reset with beats still pending
        u[0] = mk(UJ); u[1] = mk(STD); u[2] = mk(STD); u[3] = mk(STD);
        drive(4'b1111, u, 1'b1, 1'b1);
        drive(4'b0000, u, 1'b1, 1'b1);
        drive(4'b0000, u, 1'b0, 1'b1);
        drive(4'b0000, u, 1'b0, 1'b0);
        drive(4'b0000, u, 1'b1, 1'b0);
        drive(4'b0000, u, 1'b1, 1'b1);
        drive(4'b0000, u, 1'b1, 1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) u[i] = mk(rnd_type());
            drive(4'($urandom), u, ($urandom_range(0, 3) != 0), ($urandom_range(0, 399) != 0));
        end
        drive(4'b0000, u, 1'b1, 1'b1);
        wait_idle();
        drive(4'b0000, u, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/te_ingress_serializer.md
Name: te_ingress_serializer

Overview:
- Parametrised ingress stage between the CVA6 commit ports and the trace encoder.
- Accepts a bundle of up to NrRetiredInstr retired uops per cycle and emits them one per cycle on a valid/ready stream, lowest port index first.
- Optionally compresses all-STD multi-retirement bundles into one beat carrying an instruction count.
- Drops entries that follow a trap in the same bundle.

Parameters:
- NrRetiredInstr, 4, number of commit ports (1..8).
- CompressStd, 1, 1 = all-STD bundles with more than one valid entry emit a single beat; 0 = always serialise.
- CntW, $clog2(NrRetiredInstr+1), width of count_o (derived; not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  NrRetiredInstr  per-port retire valid; any bit pattern is legal
- uop_i  in  NrRetiredInstr x mure_pkg::uop_entry_s  per-port uop; index 0 is oldest
- ready_o  out  1  bundle accepted when ready_o & |valid_i
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accept
- uop_o  out  mure_pkg::uop_entry_s  emitted uop
- count_o  out  CntW  number of retired instructions the beat represents (>=1 when valid_o)
- drop_o  out  1  one-cycle pulse: the accepted bundle contained entries discarded after a trap

Behaviour:
- Reset, async on rst_ni low:
  - valid_o=0, uop_o='0, count_o=0, drop_o=0.
  - Pending mask cleared; state IDLE.
  - Anything in flight is discarded; no partial beat after reset release.
- Trap type: itype in {EXC, INT, ERET}.
- Capture:
  - Bundle captured at clock edge when ready_o & |valid_i. valid_i=0 is never captured.
  - Capture computes the effective mask: valid_i with every bit above the lowest-index valid trap entry cleared (the trap entry itself is kept).
  - drop_o=1 on the cycle after capture iff any bit was cleared.
- Compression: when CompressStd=1, effective mask has more than one bit set, and every effective entry is STD:
  - Single beat. uop_o = highest-index effective entry; count_o = popcount(effective mask).
  - Any non-STD entry (including UJ) disables compression for the whole bundle.
- Otherwise, one beat per set bit of the effective mask, ascending index, count_o=1 each.
- States:
  - IDLE: valid_o=0. On capture, load first beat -> EMIT.
  - EMIT: valid_o=1, outputs held stable while !ready_i.
    - On ready_i with further pending bits: advance to the next lowest pending entry (stay EMIT).
    - On ready_i on the last beat with a new capture in the same cycle: load new first beat (stay EMIT).
    - On ready_i on the last beat with no capture: -> IDLE.
- ready_o = !valid_o | (ready_i & last_beat). This is combinational from ready_i and permits back-to-back bundles with zero bubble.
- Latency: capture at edge t -> first beat valid at t+1.
- Throughput: one beat per cycle while ready_i=1.
- Sparse valid_i (e.g. 4'b1010) is legal: holes are skipped with no idle cycle.
- valid_o never deasserts without a handshake. uop_o and count_o are stable while valid_o & !ready_i.
- No internal FIFO: backpressure propagates to the commit side through ready_o.

Test Plan:
- N=4, CompressStd=1, valid_i=4'b1111, all STD, ready_i=1 -> one beat at t+1, uop_o=uop_i[3], count_o=3'd4; ready_o=1 in that cycle.
- CompressStd=1, valid_i=4'b0111, itype {STD, UJ, STD} at ports 0..2 -> three beats (ports 0, 1, 2), count_o=1 each; ready_o low until the third beat handshakes.
- valid_i=4'b1111, port1 itype=EXC -> beats for port0 then port1 only; drop_o pulses once at t+1; ports 2 and 3 are never emitted.
- valid_i=4'b1010, CompressStd=0, ready_i held 0 for 3 cycles -> uop_o=uop_i[1] stable for 4 cycles, then uop_i[3] on the next cycle; no beat for ports 0 or 2.
- Back-to-back: bundle A=4'b0001 STD, bundle B presented on the next cycle -> B captured on the cycle A handshakes; valid_o continuously high, no bubble.
- Assert rst_ni low mid-serialisation (two beats pending) -> valid_o=0 immediately; after release, IDLE with ready_o=1 and no stale beats.
